// File: rtl/quant_param_icb_if.sv
// ICB command/response bundle between the requant engine (or CPU/DMA)
// and the quant parameter store.
interface quant_param_icb_if #(
    parameter int AW = 32
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic [1:0]    icb_cmd_size;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [31:0]   icb_rsp_rdata;
    logic          icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
        output icb_cmd_wdata, icb_cmd_wmask, icb_cmd_size,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
        input  icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
        input  icb_cmd_wdata, icb_cmd_wmask, icb_cmd_size,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
        output icb_rsp_err
    );
endinterface

// File: rtl/quant_param_icb_slave.sv
// ICB responder holding per-channel requant multiplier/shift words,
// with a 2-entry in-order response FIFO and a zero-fill scrub sequence.
module quant_param_icb_slave #(
    parameter int            DEPTH     = 64,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    output logic             busy_o,
    quant_param_icb_if.slave icb
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] SPAN = AW'(DEPTH * 4);

    typedef enum logic {
        S_IDLE,
        S_SCRUB
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] scrub_q, scrub_d;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   fdat_q [2];
    logic          ferr_q [2];
    logic          wp_q, rp_q;
    logic [1:0]    cnt_q;

    logic [AW-1:0] off;
    logic [IW-1:0] idx;
    logic          dec_err;
    logic          accept;
    logic          pop;
    logic          wr_en;
    logic [31:0]   rd_d;

    assign off = icb.icb_cmd_addr - BASE_ADDR;
    assign idx = off[IW+1:2];

    assign dec_err = (icb.icb_cmd_addr < BASE_ADDR)
                  || (off >= SPAN)
                  || (icb.icb_cmd_addr[1:0] != 2'b00)
                  || (icb.icb_cmd_size != 2'b10);

    // Response is pushed at the accept edge, so FIFO occupancy alone
    // bounds outstanding commands.
    assign icb.icb_cmd_ready = rstn && (state_q == S_IDLE)
                            && (cnt_q != 2'd2);

    assign accept = icb.icb_cmd_valid && icb.icb_cmd_ready;
    assign pop    = icb.icb_rsp_valid && icb.icb_rsp_ready;
    assign wr_en  = accept && !icb.icb_cmd_read && !dec_err;
    assign rd_d   = (icb.icb_cmd_read && !dec_err) ? mem_q[idx] : 32'h0;

    assign icb.icb_rsp_valid = (cnt_q != 2'd0);
    assign icb.icb_rsp_rdata = fdat_q[rp_q];
    assign icb.icb_rsp_err   = ferr_q[rp_q];
    assign busy_o            = (state_q == S_SCRUB);

    always_comb begin
        state_d = state_q;
        scrub_d = scrub_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    state_d = S_SCRUB;
                    scrub_d = '0;
                end
            end
            S_SCRUB: begin
                scrub_d = scrub_q + 1'b1;
                if (scrub_q == IW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            scrub_q <= '0;
        end else begin
            state_q <= state_d;
            scrub_q <= scrub_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fdat_q[0] <= '0;
            fdat_q[1] <= '0;
            ferr_q[0] <= 1'b0;
            ferr_q[1] <= 1'b0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                fdat_q[wp_q] <= rd_d;
                ferr_q[wp_q] <= dec_err;
                wp_q         <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, accept} - {1'b0, pop};
        end
    end

    // Contents are undefined after reset; software scrubs before use.
    always_ff @(posedge clk) begin
        if (state_q == S_SCRUB) begin
            mem_q[scrub_q] <= '0;
        end else if (wr_en) begin
            if (icb.icb_cmd_wmask[0]) mem_q[idx][7:0]   <= icb.icb_cmd_wdata[7:0];
            if (icb.icb_cmd_wmask[1]) mem_q[idx][15:8]  <= icb.icb_cmd_wdata[15:8];
            if (icb.icb_cmd_wmask[2]) mem_q[idx][23:16] <= icb.icb_cmd_wdata[23:16];
            if (icb.icb_cmd_wmask[3]) mem_q[idx][31:24] <= icb.icb_cmd_wdata[31:24];
        end
    end
endmodule

// File: tb/tb_quant_param_icb_slave.sv
// Scoreboard bench for quant_param_icb_slave: random and directed ICB
// traffic checked against a word-array reference model.
module tb_quant_param_icb_slave;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic clr  = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    quant_param_icb_if #(.AW(32)) icb ();

    quant_param_icb_slave #(
        .DEPTH    (DEPTH),
        .AW       (32),
        .BASE_ADDR(BASE)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (clr),
        .busy_o(busy),
        .icb   (icb)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t_acc = 0;
    int          t_last = 0;
    int          t_first = 0;
    bit          rnd = 0;
    logic [31:0] mm [DEPTH];
    logic [32:0] sb [$];
    bit          hold = 0;
    logic [32:0] held;
    logic [32:0] expv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference: decode by plain arithmetic on byte addresses.
    function automatic logic [32:0] model(input bit rd, input logic [31:0] a,
                                          input logic [31:0] wd,
                                          input logic [3:0] wm,
                                          input logic [1:0] sz);
        longint off;
        bit     err;
        int     i;
        off = longint'(a) - longint'(BASE);
        err = (off < 0) || (off >= DEPTH * 4) || (a % 4 != 0) || (sz != 2'b10);
        if (err) return {1'b1, 32'h0};
        i = int'(off / 4);
        if (rd) return {1'b0, mm[i]};
        for (int b = 0; b < 4; b++)
            if (wm[b]) mm[i][8*b +: 8] = wd[8*b +: 8];
        return {1'b0, 32'h0};
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            hold = 0;
        end else begin
            if (hold)
                chk("rsp_stable", {31'b0, icb.icb_rsp_err, icb.icb_rsp_rdata},
                    {31'b0, held});
            if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got response, required none");
                end else begin
                    expv = sb.pop_front();
                    chk("rdata", icb.icb_rsp_rdata, expv[31:0]);
                    chk("err", icb.icb_rsp_err, expv[32]);
                    t_last = cyc;
                end
            end
            hold = icb.icb_rsp_valid && !icb.icb_rsp_ready;
            held = {icb.icb_rsp_err, icb.icb_rsp_rdata};
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input logic [1:0] sz);
        int n;
        n = 0;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = wm;
        icb.icb_cmd_size  = sz;
        @(negedge clk);
        while (!icb.icb_cmd_ready && n < 100) begin
            sync();
            if (rnd) icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
            n++;
            @(negedge clk);
        end
        if (!icb.icb_cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL cmd_timeout: cmd_ready 0, required 1 within 100 cycles");
        end else begin
            sb.push_back(model(rd, a, wd, wm, sz));
            t_acc = cyc;
        end
        sync();
        icb.icb_cmd_valid = 1'b0;
        if (rnd) icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        sync();
        clr = 1'b0;
    endtask

    task automatic wait_scrub();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            chk("scrub_cmd_ready", icb.icb_cmd_ready, 0);
            @(negedge clk);
        end
        chk("scrub_len", n, DEPTH);
        foreach (mm[i]) mm[i] = '0;
        sync();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d responses pending, required 0", sb.size());
        end
        sync();
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          sel;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_cmd_size  = 2'b10;
        icb.icb_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", icb.icb_cmd_ready, 0);
        chk("rst_rsp_valid", icb.icb_rsp_valid, 0);
        chk("rst_rdata", icb.icb_rsp_rdata, 0);
        chk("rst_err", icb.icb_rsp_err, 0);
        chk("rst_busy", busy, 0);
        sync();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", icb.icb_cmd_ready, 1);
        sync();

        pulse_clr();
        wait_scrub();

        do_cmd(0, BASE + 32'h4, 32'h1234_5678, 4'hF, 2'b10);
        do_cmd(1, BASE + 32'h4, 0, 0, 2'b10);
        @(negedge clk);
        chk("read_latency", icb.icb_rsp_valid, 1);
        sync();
        do_cmd(0, BASE + 32'h4, 32'hAAAA_AAAA, 4'b0010, 2'b10);
        do_cmd(1, BASE + 32'h4, 0, 0, 2'b10);

        do_cmd(1, BASE + DEPTH * 4, 0, 0, 2'b10);
        do_cmd(0, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_cmd(1, BASE, 0, 0, 2'b10);
        do_cmd(1, BASE + 32'h8, 0, 0, 2'b01);
        drain();

        icb.icb_rsp_ready = 1'b0;
        do_cmd(1, BASE + 32'h4, 0, 0, 2'b10);
        do_cmd(1, BASE + 32'h0, 0, 0, 2'b10);
        @(negedge clk);
        chk("full_cmd_ready", icb.icb_cmd_ready, 0);
        chk("full_rsp_valid", icb.icb_rsp_valid, 1);
        sync();
        icb.icb_rsp_ready = 1'b1;
        do_cmd(1, BASE + 32'hC, 0, 0, 2'b10);
        drain();

        for (int i = 0; i < DEPTH; i++)
            do_cmd(0, BASE + 32'(i * 4), $urandom, 4'hF, 2'b10);
        for (int i = 0; i < 8; i++)
            do_cmd(1, BASE + 32'($urandom_range(0, DEPTH - 1) * 4), 0, 0, 2'b10);
        drain();
        pulse_clr();
        wait_scrub();
        for (int i = 0; i < DEPTH; i++)
            do_cmd(1, BASE + 32'(i * 4), 0, 0, 2'b10);
        drain();

        clr = 1'b1;
        do_cmd(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b10);
        clr = 1'b0;
        wait_scrub();
        do_cmd(1, BASE + 32'h10, 0, 0, 2'b10);
        drain();

        rnd = 1;
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel == 7) a = 32'($urandom_range(0, 300));
            else if (sel == 8) a = BASE + DEPTH * 4 + 32'($urandom_range(0, 255)) * 4;
            else               a = $urandom;
            sz = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            do_cmd(1'($urandom_range(0, 1)), a, $urandom,
                   4'($urandom_range(0, 15)), sz);
        end
        rnd = 0;
        icb.icb_rsp_ready = 1'b1;
        drain();

        icb.icb_rsp_ready = 1'b0;
        do_cmd(1, BASE + 32'h8, 0, 0, 2'b10);
        pulse_clr();
        repeat (10) @(negedge clk);
        chk("scrub_busy", busy, 1);
        chk("scrub_rsp_held", icb.icb_rsp_valid, 1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", icb.icb_rsp_valid, 0);
        chk("abort_cmd_ready", icb.icb_cmd_ready, 0);
        sb.delete();
        sync();
        rstn = 1'b1;
        icb.icb_rsp_ready = 1'b1;
        pulse_clr();
        wait_scrub();

        for (int i = 0; i < 32; i++) begin
            do_cmd(1, BASE + 32'(i * 4), 0, 0, 2'b10);
            if (i == 0) t_first = t_acc;
        end
        drain();
        chk("b2b_span", t_last - t_first, 32);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
